ps2_direction_scheduler: RTL and testbench

//  Sits between PS2_Controller (received_data / received_data_en) and the game FSM.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_direction_scheduler_dir_fifo.sv | 55 +++++
 rtl/ps2_direction_scheduler.sv | 130 +++++++++++++
 tb/tb_ps2_direction_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 scancode constants, direction encodings and parser state type.
package ps2_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    PS_IDLE,
    PS_EXT,
    PS_BRK,
    PS_EXT_BRK
  } parse_state_t;

  function automatic logic is_dir_code(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) || (code == SC_LEFT) || (code == SC_RIGHT);
  endfunction

  function automatic logic [1:0] code_to_dir(input logic [7:0] code);
    logic [1:0] d;
    d = DIR_UP;
    case (code)
      SC_DOWN:  d = DIR_DOWN;
      SC_LEFT:  d = DIR_LEFT;
      SC_RIGHT: d = DIR_RIGHT;
      default:  d = DIR_UP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ps2_direction_scheduler_dir_fifo.sv
// Show-ahead FIFO of 2-bit direction codes; a push on a full FIFO is accepted only with a same-cycle pop.
module dir_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [1:0]               push_data,
  input  logic                     pop,
  output logic [1:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_direction_scheduler.sv
// PS/2 scancode parser, held-key tracker and filtered direction queue feeding the game FSM.
module ps2_direction_scheduler
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYC   = 100000,
  parameter int REPEAT_EN     = 0,
  parameter int BLOCK_REVERSE = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          KEY,
  input  logic                          EN,
  input  logic [7:0]                    rx_data,
  input  logic                          rx_valid,
  input  logic                          dir_ready,
  output logic                          dir_valid,
  output logic [1:0]                    dir,
  output logic [3:0]                    held,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  parse_state_t state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          make_ev;
  logic          brk_ev;
  logic          code_is_dir;
  logic [1:0]    code_dir;
  logic [1:0]    last_dir;
  logic          last_valid;
  logic          en_d;
  logic          en_fall;
  logic          reverse_hit;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          empty;

  assign code_is_dir = is_dir_code(rx_data);
  assign code_dir    = code_to_dir(rx_data);

  always_comb begin
    state_nxt = state;
    make_ev   = 1'b0;
    brk_ev    = 1'b0;
    if (rx_valid) begin
      case (state)
        PS_IDLE: begin
          if (rx_data == SC_EXT)      state_nxt = PS_EXT;
          else if (rx_data == SC_BRK) state_nxt = PS_BRK;
          else                        make_ev   = code_is_dir;
        end
        PS_EXT: begin
          if (rx_data == SC_EXT)      state_nxt = PS_EXT;
          else if (rx_data == SC_BRK) state_nxt = PS_EXT_BRK;
          else begin
            make_ev   = code_is_dir;
            state_nxt = PS_IDLE;
          end
        end
        default: begin
          brk_ev    = code_is_dir;
          state_nxt = PS_IDLE;
        end
      endcase
    end else if (state != PS_IDLE && tmo_cnt == '0) begin
      state_nxt = PS_IDLE;
    end
  end

  // Counter is loaded with TIMEOUT_CYC-1 so a prefix aborts on the TIMEOUT_CYC-th idle edge.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      state   <= PS_IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rx_valid)            tmo_cnt <= TW'(TIMEOUT_CYC - 1);
      else if (tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign dir_valid   = !empty && EN;
  assign pop         = dir_valid && dir_ready;
  assign en_fall     = en_d && !EN;
  assign reverse_hit = (BLOCK_REVERSE != 0) && last_valid && (code_dir == (last_dir ^ 2'b01));
  assign push_req    = make_ev && EN && (!held[code_dir] || (REPEAT_EN != 0)) && !reverse_hit;
  assign push_ok     = push_req && (!full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (!KEY) begin
      held       <= '0;
      last_dir   <= DIR_UP;
      last_valid <= 1'b0;
      overflow   <= 1'b0;
      en_d       <= 1'b0;
    end else begin
      en_d <= EN;
      if (make_ev)     held[code_dir] <= 1'b1;
      else if (brk_ev) held[code_dir] <= 1'b0;
      if (en_fall) begin
        last_valid <= 1'b0;
        overflow   <= 1'b0;
      end else begin
        if (push_ok) begin
          last_dir   <= code_dir;
          last_valid <= 1'b1;
        end
        if (push_req && full && !pop) overflow <= 1'b1;
      end
    end
  end

  dir_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (KEY),
    .flush     (!EN),
    .push      (push_req),
    .push_data (code_dir),
    .pop       (pop),
    .head      (dir),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_ps2_direction_scheduler.sv
// Directed bench for ps2_direction_scheduler with a shortened prefix timeout.
module tb_ps2_direction_scheduler;

  logic       CLOCK_50 = 1'b0;
  logic       KEY = 1'b0;
  logic       EN = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       dir_ready = 1'b0;
  logic       dir_valid;
  logic [1:0] dir;
  logic [3:0] held;
  logic [2:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ps2_direction_scheduler #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYC   (50),
    .REPEAT_EN     (0),
    .BLOCK_REVERSE (1)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .KEY        (KEY),
    .EN         (EN),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .dir_ready  (dir_ready),
    .dir_valid  (dir_valid),
    .dir        (dir),
    .held       (held),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLOCK_50);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask

  task automatic tap(input logic [7:0] code);
    send_byte(code);
    send_byte(8'hF0);
    send_byte(code);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic pop_check(input string tag, input logic [1:0] exp);
    check(tag, 8'(dir), 8'(exp));
    @(negedge CLOCK_50);
    dir_ready = 1'b1;
    @(negedge CLOCK_50);
    dir_ready = 1'b0;
  endtask

  task automatic en_pulse();
    @(negedge CLOCK_50);
    EN = 1'b0;
    @(negedge CLOCK_50);
    EN = 1'b1;
  endtask

  initial begin
    idle(3);
    check("rst_valid", 8'(dir_valid), 8'h0);
    check("rst_dir", 8'(dir), 8'h0);
    check("rst_held", 8'(held), 8'h0);
    check("rst_count", 8'(fifo_count), 8'h0);
    check("rst_ovf", 8'(overflow), 8'h0);
    KEY = 1'b1;

    // 1: arrow up make
    send_byte(8'hE0);
    send_byte(8'h75);
    check("t1_valid", 8'(dir_valid), 8'h1);
    check("t1_dir", 8'(dir), 8'h0);
    check("t1_held", 8'(held), 8'h1);
    check("t1_count", 8'(fifo_count), 8'h1);

    // 2: arrow up break, then reverse (down) blocked
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("t2_held", 8'(held), 8'h0);
    check("t2_count", 8'(fifo_count), 8'h1);
    send_byte(8'h72);
    check("t2_rev_count", 8'(fifo_count), 8'h1);
    check("t2_rev_held", 8'(held), 8'h2);
    send_byte(8'hF0);
    send_byte(8'h72);
    check("t2_rel_held", 8'(held), 8'h0);
    pop_check("t2_head", 2'b00);
    check("t2_drained", 8'(fifo_count), 8'h0);

    // 3: five taps overflow a 4-deep queue
    tap(8'h75);
    tap(8'h6B);
    tap(8'h75);
    tap(8'h74);
    tap(8'h75);
    check("t3_count", 8'(fifo_count), 8'h4);
    check("t3_ovf", 8'(overflow), 8'h1);
    pop_check("t3_head0", 2'b00);
    pop_check("t3_head1", 2'b10);
    pop_check("t3_head2", 2'b00);
    pop_check("t3_head3", 2'b11);
    check("t3_empty", 8'(dir_valid), 8'h0);

    // 4: prefix timeout
    send_byte(8'hE0);
    idle(40);
    send_byte(8'h74);
    check("t4_ext_count", 8'(fifo_count), 8'h1);
    check("t4_ext_dir", 8'(dir), 8'h3);
    send_byte(8'hF0);
    send_byte(8'h74);
    check("t4_rel_held", 8'(held), 8'h0);
    send_byte(8'hF0);
    idle(40);
    send_byte(8'h74);
    check("t4_brk_held", 8'(held), 8'h0);
    check("t4_brk_count", 8'(fifo_count), 8'h1);
    send_byte(8'hF0);
    idle(51);
    send_byte(8'h74);
    check("t4_tmo_held", 8'(held), 8'h8);
    check("t4_tmo_count", 8'(fifo_count), 8'h2);
    send_byte(8'hF0);
    send_byte(8'h74);
    pop_check("t4_head0", 2'b11);
    pop_check("t4_head1", 2'b11);

    // 5: push and pop together on a full queue
    en_pulse();
    check("t5_ovf_clr", 8'(overflow), 8'h0);
    tap(8'h75);
    tap(8'h6B);
    tap(8'h75);
    tap(8'h74);
    check("t5_full", 8'(fifo_count), 8'h4);
    @(negedge CLOCK_50);
    rx_data   = 8'h72;
    rx_valid  = 1'b1;
    dir_ready = 1'b1;
    @(negedge CLOCK_50);
    rx_valid  = 1'b0;
    dir_ready = 1'b0;
    check("t5_count", 8'(fifo_count), 8'h4);
    check("t5_ovf", 8'(overflow), 8'h0);
    pop_check("t5_head0", 2'b10);
    pop_check("t5_head1", 2'b00);
    pop_check("t5_head2", 2'b11);
    pop_check("t5_tail", 2'b01);
    send_byte(8'hF0);
    send_byte(8'h72);

    // 6: repeats dropped, EN flush, reset mid-prefix
    en_pulse();
    send_byte(8'h75);
    send_byte(8'h75);
    send_byte(8'h75);
    check("t6_rep_count", 8'(fifo_count), 8'h1);
    check("t6_rep_held", 8'(held), 8'h1);
    @(negedge CLOCK_50);
    EN = 1'b0;
    #1;
    check("t6_en_valid", 8'(dir_valid), 8'h0);
    @(negedge CLOCK_50);
    check("t6_en_count", 8'(fifo_count), 8'h0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("t6_en_held", 8'(held), 8'h0);
    EN = 1'b1;
    send_byte(8'hE0);
    send_byte(8'hF0);
    KEY = 1'b0;
    @(negedge CLOCK_50);
    check("t6_rst_valid", 8'(dir_valid), 8'h0);
    check("t6_rst_dir", 8'(dir), 8'h0);
    check("t6_rst_held", 8'(held), 8'h0);
    check("t6_rst_count", 8'(fifo_count), 8'h0);
    check("t6_rst_ovf", 8'(overflow), 8'h0);
    KEY = 1'b1;
    send_byte(8'h75);
    check("t6_post_held", 8'(held), 8'h1);
    check("t6_post_count", 8'(fifo_count), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
